// File: rtl/bvic_pkg.sv
// Shared definitions for the bit-vector invertibility-condition blocks:
// operator codes, the sequencer state type and the IC / match helper functions.
package bvic_pkg;

  localparam logic OP_UGT = 1'b0;
  localparam logic OP_ULT = 1'b1;
  localparam int   MAX_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Closed-form IC for x*s OP t. Operands are zero-extended to MAX_W; mask
  // selects the live width so that -s wraps at the real operand width.
  function automatic logic ic_bvmul(input logic op,
                                    input logic [MAX_W-1:0] s,
                                    input logic [MAX_W-1:0] t,
                                    input logic [MAX_W-1:0] mask);
    logic [MAX_W-1:0] neg;
    logic             ic;
    neg = (16'd0 - s) & mask;
    if (op == OP_UGT) begin
      ic = (t < (neg | s));
    end else begin
      ic = (t != 16'd0);
    end
    return ic;
  endfunction

  function automatic logic match_cmp(input logic op,
                                     input logic [MAX_W-1:0] p,
                                     input logic [MAX_W-1:0] t);
    logic m;
    if (op == OP_UGT) begin
      m = (p > t);
    end else begin
      m = (p < t);
    end
    return m;
  endfunction

endpackage

// File: rtl/bvmul_cmp_ic.sv
// Combinational IC and candidate-match evaluator for x*s OP t (mod 2^W).
// Reusable by sibling IC blocks that need the same operator conventions.
module bvmul_cmp_ic #(
  parameter int W = 4
) (
  input  logic         op,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  input  logic [W-1:0] x,
  output logic         ic,
  output logic         match
);
  import bvic_pkg::*;

  localparam logic [MAX_W-1:0] MASK = MAX_W'((32'd1 << W) - 32'd1);

  logic [W-1:0] prod_s;

  // Full 2W-bit product, truncated to the low W bits.
  assign prod_s = W'({{W{1'b0}}, x} * {{W{1'b0}}, s});

  assign ic    = ic_bvmul(op, MAX_W'(s), MAX_W'(t), MASK);
  assign match = match_cmp(op, MAX_W'(prod_s), MAX_W'(t));

endmodule

// File: rtl/bvmul_cmp_skolem_seq.sv
// Sequential Skolem-witness generator for x*s OP t: evaluates the closed-form
// IC, scans x = 0..2^W-1 for the smallest witness and flags IC/search mismatch.
module bvmul_cmp_skolem_seq #(
  parameter int W        = 4,
  parameter int SHORTCUT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_op,
  input  logic [W-1:0] req_s,
  input  logic [W-1:0] req_t,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_found,
  output logic [W-1:0] resp_x,
  output logic         resp_ic,
  output logic         resp_ic_err
);
  import bvic_pkg::*;

  localparam logic [W-1:0] CNT_LAST = {W{1'b1}};
  localparam logic         USE_SHORTCUT = (SHORTCUT != 0);

  state_t       state_r, state_nx;
  logic [W-1:0] cnt_r, cnt_nx;
  logic         op_r, op_nx;
  logic [W-1:0] s_r, s_nx;
  logic [W-1:0] t_r, t_nx;
  logic         ic_r, ic_nx;
  logic         valid_r, valid_nx;
  logic         ready_r, ready_nx;
  logic         found_r, found_nx;
  logic [W-1:0] x_r, x_nx;
  logic         err_r, err_nx;

  logic         sel_op_s;
  logic [W-1:0] sel_s_s, sel_t_s;
  logic         ic_s, match_s;

  // While idle the evaluator looks at the live request so the shortcut can be
  // decided on the accept edge; afterwards it looks at the captured operands.
  assign sel_op_s = (state_r == IDLE) ? req_op : op_r;
  assign sel_s_s  = (state_r == IDLE) ? req_s  : s_r;
  assign sel_t_s  = (state_r == IDLE) ? req_t  : t_r;

  bvmul_cmp_ic #(.W(W)) u_ic (
    .op    (sel_op_s),
    .s     (sel_s_s),
    .t     (sel_t_s),
    .x     (cnt_r),
    .ic    (ic_s),
    .match (match_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    op_nx    = op_r;
    s_nx     = s_r;
    t_nx     = t_r;
    ic_nx    = ic_r;
    valid_nx = valid_r;
    ready_nx = ready_r;
    found_nx = found_r;
    x_nx     = x_r;
    err_nx   = err_r;
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          op_nx    = req_op;
          s_nx     = req_s;
          t_nx     = req_t;
          ic_nx    = ic_s;
          ready_nx = 1'b0;
          cnt_nx   = {W{1'b0}};
          if (USE_SHORTCUT && !ic_s) begin
            state_nx = RESP;
            valid_nx = 1'b1;
            found_nx = 1'b0;
            x_nx     = {W{1'b0}};
            err_nx   = 1'b0;
          end else begin
            state_nx = SEARCH;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      SEARCH: begin
        if (match_s) begin
          state_nx = RESP;
          valid_nx = 1'b1;
          found_nx = 1'b1;
          x_nx     = cnt_r;
          err_nx   = ~ic_r;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = RESP;
          valid_nx = 1'b1;
          found_nx = 1'b0;
          x_nx     = {W{1'b0}};
          err_nx   = ic_r;
        end else begin
          cnt_nx = cnt_r + {{(W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          ready_nx = 1'b1;
        end else begin
          state_nx = RESP;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        ready_nx = 1'b1;
      end
    endcase
  end

  // State, captured request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {W{1'b0}};
      op_r    <= 1'b0;
      s_r     <= {W{1'b0}};
      t_r     <= {W{1'b0}};
      ic_r    <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      found_r <= 1'b0;
      x_r     <= {W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      op_r    <= op_nx;
      s_r     <= s_nx;
      t_r     <= t_nx;
      ic_r    <= ic_nx;
      valid_r <= valid_nx;
      ready_r <= ready_nx;
      found_r <= found_nx;
      x_r     <= x_nx;
      err_r   <= err_nx;
    end
  end

  assign req_ready   = ready_r;
  assign resp_valid  = valid_r;
  assign resp_found  = found_r;
  assign resp_x      = x_r;
  assign resp_ic     = ic_r;
  assign resp_ic_err = err_r;

endmodule
